muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide execution unit sitting directly downstream of the register file. It consumes the two operand values read from the register file, runs a one-bit-per-cycle shift-add or restoring-divide loop, and hands the result back as a write-back request. The write-back request consists of a one-cycle write enable, a destination address and a value. The pipeline stalls on `busy` while an operation is in flight.

---
 rtl/definitions_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 69 ++++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared definitions for the multiply/divide execution unit.
//
// Contents:
//   DATA_WIDTH    - operand and result width
//   REG_WIDTH     - register-file address width
//   CNT_WIDTH     - iteration counter width ($clog2(DATA_WIDTH)+1)
//   muldiv_op_t   - MUL=0, MULHU=1, DIVU=2, REMU=3
//   muldiv_state_t- IDLE, RUN, DONE
//   is_div_op()   - true for DIVU/REMU
package definitions;

    localparam int DATA_WIDTH = 8;
    localparam int REG_WIDTH  = 5;
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        MUL   = 2'd0,
        MULHU = 2'd1,
        DIVU  = 2'd2,
        REMU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == DIVU) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide loop, purely combinational.
//
// Register layout shared by both op classes:
//   hi   - multiply: upper product half      divide: partial remainder
//   lo   - multiply: multiplier / low half   divide: dividend shifting into quotient
//   opnd - multiply: multiplicand            divide: divisor
//
// Ports:
//   is_div  in  1           - 1 selects a restoring-divide step, 0 a shift-add step
//   hi      in  DATA_WIDTH  - current hi register
//   lo      in  DATA_WIDTH  - current lo register
//   opnd    in  DATA_WIDTH  - multiplicand or divisor
//   hi_next out DATA_WIDTH  - hi after this step
//   lo_next out DATA_WIDTH  - lo after this step
//
// Build option: MULDIV_DIV_EN includes the divide step; without it only the
// shift-add step exists and is_div is ignored.
module muldiv_step
    import definitions::*;
(
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] opnd,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic [DATA_WIDTH-1:0] lo_next
);

    // Shift-add: conditionally add, then shift the {carry, hi, lo} chain right.
    logic [DATA_WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, hi};
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, opnd};
        end
    end

`ifdef MULDIV_DIV_EN
    // Restoring divide: the shifted remainder needs one extra bit, but the
    // stored remainder always fits DATA_WIDTH bits (it stays below a nonzero
    // divisor, and with a zero divisor it is a prefix of the dividend).
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                ge;

    always_comb begin
        shifted = {hi, lo[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        ge      = (shifted >= {1'b0, opnd});
        if (is_div) begin
            hi_next = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            lo_next = {lo[DATA_WIDTH-2:0], ge};
        end else begin
            hi_next = sum[DATA_WIDTH:1];
            lo_next = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;

    always_comb begin
        hi_next = sum[DATA_WIDTH:1];
        lo_next = {sum[0], lo[DATA_WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit behind the register file.
// Accepts an operation in IDLE, runs one bit per cycle in RUN, and issues a
// one-cycle write-back request in DONE.
//
// Ports:
//   _CLK       in  1           - clock, rising edge
//   _RST_N     in  1           - synchronous active-low reset
//   _start     in  1           - request; accepted only in IDLE
//   _op        in  muldiv_op_t - MUL / MULHU / DIVU / REMU, sampled with _start
//   _operandA  in  DATA_WIDTH  - multiplicand or dividend
//   _operandB  in  DATA_WIDTH  - multiplier or divisor
//   _destReg   in  REG_WIDTH   - write-back address, sampled with _start
//   busy       out 1           - high in RUN and DONE
//   regWrite   out 1           - write-back strobe, DONE only
//   regDest    out REG_WIDTH   - latched destination, 0 outside DONE
//   result     out DATA_WIDTH  - result value, 0 outside DONE
//   divZero    out 1           - zero divisor on DIVU/REMU, with regWrite
//   illegal    out 1           - division requested but not built, with regWrite
//   dbg_state  out state       - current FSM state
//
// Handshake: a request is taken on a rising edge where _start=1 and the unit
// is in IDLE; any other _start is dropped, never queued. The unit answers with
// exactly one regWrite cycle per accepted request (unless reset intervenes),
// and holds busy from the cycle after acceptance through the regWrite cycle.
//
// Build option: MULDIV_DIV_EN includes the divider. Without it DIVU/REMU are
// accepted and complete one cycle later with illegal=1 and result=0.
module muldiv_unit
    import definitions::*;
(
    input  logic                  _CLK,
    input  logic                  _RST_N,
    input  logic                  _start,
    input  muldiv_op_t            _op,
    input  logic [DATA_WIDTH-1:0] _operandA,
    input  logic [DATA_WIDTH-1:0] _operandB,
    input  logic [REG_WIDTH-1:0]  _destReg,
    output logic                  busy,
    output logic                  regWrite,
    output logic [REG_WIDTH-1:0]  regDest,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  divZero,
    output logic                  illegal,
    output muldiv_state_t         dbg_state
);

    muldiv_state_t         state;
    muldiv_state_t         state_next;
    logic                  accept;
    logic                  finish;

    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    muldiv_op_t            op_q;
    logic [REG_WIDTH-1:0]  dest_q;
    logic                  div_zero_q;

    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] opnd;
    logic [DATA_WIDTH-1:0] hi_next;
    logic [DATA_WIDTH-1:0] lo_next;
    logic [DATA_WIDTH-1:0] done_value;

    assign dbg_state = state;
    assign cnt_inc   = cnt + CNT_WIDTH'(1);

    muldiv_step u_step (
        .is_div  (is_div_op(op_q)),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // MULHU/REMU read the hi register, MUL/DIVU the lo register; the last
    // step's output is taken directly so DONE follows the final RUN cycle.
    assign done_value = (op_q == MULHU || op_q == REMU) ? hi_next : lo_next;

    // Next-state logic
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (_start) begin
                    accept     = 1'b1;
`ifdef MULDIV_DIV_EN
                    state_next = RUN;
`else
                    state_next = is_div_op(_op) ? DONE : RUN;
`endif
                end
            end
            RUN: begin
                if (cnt_inc == CNT_WIDTH'(DATA_WIDTH)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge _CLK) begin
        if (!_RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= MUL;
            dest_q     <= '0;
            div_zero_q <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt        <= '0;
                op_q       <= _op;
                dest_q     <= _destReg;
                div_zero_q <= is_div_op(_op) && (_operandB == '0);
                hi         <= '0;
                if (is_div_op(_op)) begin
                    lo   <= _operandA;
                    opnd <= _operandB;
                end else begin
                    lo   <= _operandB;
                    opnd <= _operandA;
                end
            end else if (state == RUN) begin
                cnt <= cnt_inc;
                hi  <= hi_next;
                lo  <= lo_next;
            end
        end
    end

    // Output registers: everything is zero outside the DONE cycle.
    always_ff @(posedge _CLK) begin
        if (!_RST_N) begin
            busy     <= 1'b0;
            regWrite <= 1'b0;
            regDest  <= '0;
            result   <= '0;
            divZero  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            busy     <= (state_next != IDLE);
            regWrite <= 1'b0;
            regDest  <= '0;
            result   <= '0;
            divZero  <= 1'b0;
            illegal  <= 1'b0;
            if (finish) begin
                regWrite <= 1'b1;
                regDest  <= dest_q;
                result   <= done_value;
                divZero  <= div_zero_q;
            end
`ifndef MULDIV_DIV_EN
            else if (accept && is_div_op(_op)) begin
                regWrite <= 1'b1;
                regDest  <= _destReg;
                illegal  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (DATA_WIDTH = 8). Expected values are
// hand-computed; division expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;
    import definitions::*;

    localparam int LAT_RUN = DATA_WIDTH + 1;  // negedges from accept edge to the DONE cycle
    localparam int LAT_ILL = 1;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    muldiv_op_t            op_s;
    logic [DATA_WIDTH-1:0] a_s;
    logic [DATA_WIDTH-1:0] b_s;
    logic [REG_WIDTH-1:0]  dest_s;
    logic                  busy;
    logic                  reg_write;
    logic [REG_WIDTH-1:0]  reg_dest;
    logic [DATA_WIDTH-1:0] result;
    logic                  div_zero;
    logic                  illegal;
    muldiv_state_t         dbg_state;

    int vectors;
    int miscompares;
    logic [DATA_WIDTH-1:0] exp_q[$];
    int pulses[$];

    muldiv_unit dut (
        ._CLK      (clk),
        ._RST_N    (rst_n),
        ._start    (start),
        ._op       (op_s),
        ._operandA (a_s),
        ._operandB (b_s),
        ._destReg  (dest_s),
        .busy      (busy),
        .regWrite  (reg_write),
        .regDest   (reg_dest),
        .result    (result),
        .divZero   (div_zero),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, follow it to its regWrite cycle and check it.
    // poke_at > 0 re-pulses _start with other operands at that RUN cycle.
    task automatic run_op(input string tag, input muldiv_op_t op,
                          input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                          input logic [REG_WIDTH-1:0] dest, input logic [DATA_WIDTH-1:0] exp_res,
                          input logic exp_dz, input logic exp_ill, input int exp_lat,
                          input int poke_at);
        int  n;
        bit  seen;
        logic [DATA_WIDTH-1:0] exp_val;
        exp_q.push_back(exp_res);
        op_s   = op;
        a_s    = a;
        b_s    = b;
        dest_s = dest;
        start  = 1'b1;
        @(posedge clk);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            a_s   = DATA_WIDTH'($urandom_range(0, 255));
            b_s   = DATA_WIDTH'($urandom_range(0, 255));
            if (n == poke_at) begin
                start  = 1'b1;
                op_s   = MUL;
                a_s    = 8'd2;
                b_s    = 8'd2;
                dest_s = 5'd7;
            end
            if (reg_write) seen = 1;
        end
        exp_val = exp_q.pop_front();
        check($sformatf("%s_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s_lat", tag), n, exp_lat);
        check($sformatf("%s_result", tag), 32'(result), 32'(exp_val));
        check($sformatf("%s_dest", tag), 32'(reg_dest), 32'(dest));
        check($sformatf("%s_divzero", tag), 32'(div_zero), 32'(exp_dz));
        check($sformatf("%s_illegal", tag), 32'(illegal), 32'(exp_ill));
        check($sformatf("%s_busy_done", tag), 32'(busy), 32'd1);
        @(negedge clk);
        check($sformatf("%s_strobe_1cyc", tag), 32'(reg_write), 32'd0);
        check($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
        check($sformatf("%s_result_after", tag), 32'(result), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op_s   = MUL;
        a_s    = '0;
        b_s    = '0;
        dest_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_regwrite", 32'(reg_write), 32'd0);
        check("rst_regdest", 32'(reg_dest), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_divzero", 32'(div_zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Multiply: 13*11 = 143; 200*3 = 600 = 0x258
        run_op("mul_13x11", MUL, 8'd13, 8'd11, 5'd3, 8'h8F, 1'b0, 1'b0, LAT_RUN, -1);
        run_op("mulhu_200x3", MULHU, 8'd200, 8'd3, 5'd4, 8'h02, 1'b0, 1'b0, LAT_RUN, -1);
        run_op("mul_200x3", MUL, 8'd200, 8'd3, 5'd9, 8'h58, 1'b0, 1'b0, LAT_RUN, -1);
        run_op("mul_ffxff", MUL, 8'hFF, 8'hFF, 5'd31, 8'h01, 1'b0, 1'b0, LAT_RUN, -1);
        run_op("mulhu_ffxff", MULHU, 8'hFF, 8'hFF, 5'd1, 8'hFE, 1'b0, 1'b0, LAT_RUN, -1);

        // Divide: 200/7 = 28 r 4; 0x5A/0 -> quotient all ones, remainder = dividend
`ifdef MULDIV_DIV_EN
        run_op("divu_200_7", DIVU, 8'd200, 8'd7, 5'd5, 8'd28, 1'b0, 1'b0, LAT_RUN, -1);
        run_op("remu_200_7", REMU, 8'd200, 8'd7, 5'd6, 8'd4, 1'b0, 1'b0, LAT_RUN, -1);
        run_op("divu_5a_0", DIVU, 8'h5A, 8'd0, 5'd8, 8'hFF, 1'b1, 1'b0, LAT_RUN, -1);
        run_op("remu_5a_0", REMU, 8'h5A, 8'd0, 5'd10, 8'h5A, 1'b1, 1'b0, LAT_RUN, -1);
`else
        run_op("divu_ill", DIVU, 8'd200, 8'd7, 5'd5, 8'd0, 1'b0, 1'b1, LAT_ILL, -1);
        run_op("remu_ill_zero", REMU, 8'h5A, 8'd0, 5'd6, 8'd0, 1'b0, 1'b1, LAT_ILL, -1);
`endif

        // _start re-pulsed during RUN is ignored
        run_op("poke_run", MUL, 8'd13, 8'd11, 5'd12, 8'h8F, 1'b0, 1'b0, LAT_RUN, 3);

        // _start held high: accepts every DATA_WIDTH+2 cycles
        op_s   = MUL;
        a_s    = 8'd5;
        b_s    = 8'd6;
        dest_s = 5'd2;
        start  = 1'b1;
        pulses.delete();
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (reg_write) begin
                pulses.push_back(i);
                check("held_result", 32'(result), 32'd30);
            end
        end
        start = 1'b0;
        check("held_count", pulses.size(), 3);
        check("held_p0", (pulses.size() > 0) ? pulses[0] : -1, LAT_RUN);
        check("held_p1", (pulses.size() > 1) ? pulses[1] : -1, LAT_RUN + DATA_WIDTH + 2);
        check("held_p2", (pulses.size() > 2) ? pulses[2] : -1, LAT_RUN + 2 * (DATA_WIDTH + 2));
        repeat (2) @(negedge clk);

        // Reset during RUN cycle 4 discards the operation
        op_s   = MUL;
        a_s    = 8'd13;
        b_s    = 8'd11;
        dest_s = 5'd3;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_outputs", {27'd0, reg_write, div_zero, illegal, 2'b00} | 32'(result) | 32'(reg_dest), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        pulses.delete();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (reg_write) pulses.push_back(i);
        end
        check("midrst_no_write", pulses.size(), 0);

        // Unit is usable again after the reset
        run_op("mul_after_rst", MUL, 8'd7, 8'd9, 5'd17, 8'd63, 1'b0, 1'b0, LAT_RUN, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
